// File: rtl/midi_uart_rx.sv
// MIDI IN serial receiver: 31250 baud 8N1, LSB first, 16x oversampling with
// 3-sample majority vote, valid/ready byte output, framing-error and overrun pulses.
module midi_uart_rx #(
  parameter int DIV_OVS = 32,
  parameter int DIV_W   = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  // Handshake: data/valid form a valid/ready pair; a byte transfers on every
  // clk edge where valid & ready are both 1, and data is stable while valid=1.

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(DIV_OVS - 1);

  state_t           state;
  logic             rxd_m;
  logic             rxd_s;
  logic [DIV_W-1:0] tick_cnt;
  logic [3:0]       s_idx;
  logic [2:0]       bit_idx;
  logic             samp7;
  logic             samp8;
  logic [7:0]       shreg;
  logic             tick;
  logic             maj;

  assign tick = (tick_cnt == TICK_LAST);
  // Only meaningful on the s=9 tick, where rxd_s is the third sample.
  assign maj  = (samp7 & samp8) | (samp7 & rxd_s) | (samp8 & rxd_s);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      s_idx     <= 4'd0;
      bit_idx   <= 3'd0;
      samp7     <= 1'b1;
      samp8     <= 1'b1;
      shreg     <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (valid && ready) valid <= 1'b0;

      if (state == IDLE) begin
        tick_cnt <= '0;
        s_idx    <= 4'd0;
        if (!rxd_s) state <= START;
      end else begin
        tick_cnt <= tick ? '0 : tick_cnt + DIV_W'(1);
        if (tick) begin
          s_idx <= s_idx + 4'd1;
          if (s_idx == 4'd7) samp7 <= rxd_s;
          if (s_idx == 4'd8) samp8 <= rxd_s;
          case (state)
            START: begin
              if (s_idx == 4'd9 && maj) begin
                state <= IDLE;
              end else if (s_idx == 4'd15) begin
                state   <= DATA;
                bit_idx <= 3'd0;
              end
            end
            DATA: begin
              if (s_idx == 4'd9) shreg <= {maj, shreg[7:1]};
              if (s_idx == 4'd15) begin
                bit_idx <= bit_idx + 3'd1;
                if (bit_idx == 3'd7) state <= STOP;
              end
            end
            STOP: begin
              // Leave STOP at mid-bit so a start edge late in the stop bit is caught.
              if (s_idx == 4'd9) begin
                if (maj) begin
                  if (!valid || ready) begin
                    data  <= shreg;
                    valid <= 1'b1;
                  end else begin
                    overrun <= 1'b1;
                  end
                  state <= IDLE;
                end else begin
                  frame_err <= 1'b1;
                  state     <= WAIT_IDLE;
                end
              end
            end
            default: ;
          endcase
        end
        if (state == WAIT_IDLE && rxd_s) state <= IDLE;
      end
    end
  end

endmodule
